// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x-oversampled deserialiser with sticky ready, frame-error and overrun flags.
// Sampling lands mid-bit; STOP hands back to IDLE at mid-stop-bit so back-to-back frames resync.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic                 rxclk_en,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [1:0]           state
);

  localparam int unsigned SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] BIT_LAST  = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_DATA  = 2'b10,
    S_STOP  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [SAMPLE_W-1:0]  sample_q, sample_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 rdy_d, frame_err_d, overrun_d;

  assign state = state_q;

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sample_q  <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data      <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      sample_q  <= sample_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data      <= data_d;
      rdy       <= rdy_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
      busy      <= (state_d != S_IDLE);
    end
  end

  // Next-state and flag logic; a good stop completion overrides a coincident rdy_clr
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data;
    rdy_d       = rdy;
    frame_err_d = frame_err;
    overrun_d   = overrun;

    if (rdy_clr) begin
      rdy_d       = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        sample_d = '0;
        idx_d    = '0;
        if (rxclk_en && !rx_s) state_d = S_START;
      end
      S_START: begin
        if (rxclk_en) begin
          if (sample_q == HALF_LAST) begin
            sample_d = '0;
            idx_d    = '0;
            state_d  = rx_s ? S_IDLE : S_DATA;
          end else begin
            sample_d = sample_q + SAMPLE_W'(1);
          end
        end
      end
      S_DATA: begin
        if (rxclk_en) begin
          if (sample_q == BIT_LAST) begin
            shift_d  = DATA_BITS'({rx_s, shift_q} >> 1);
            sample_d = '0;
            idx_d    = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) state_d = S_STOP;
          end else begin
            sample_d = sample_q + SAMPLE_W'(1);
          end
        end
      end
      S_STOP: begin
        if (rxclk_en) begin
          if (sample_q == BIT_LAST) begin
            state_d = S_IDLE;
            if (rx_s) begin
              data_d      = shift_q;
              rdy_d       = 1'b1;
              frame_err_d = 1'b0;
              if (rdy && !rdy_clr) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + SAMPLE_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames plus random frames, checked against a frame-level flag model.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rx;
  logic       rxclk_en;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Frame-level reference: what the sticky outputs should hold between frames
  logic [7:0] m_data;
  logic       m_rdy, m_fe, m_ov;
  logic       rdy_pre, rdy_post;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .rx       (rx),
    .rxclk_en (rxclk_en),
    .rdy_clr  (rdy_clr),
    .data     (data),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy),
    .state    (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".data"},      32'(data),      32'(m_data));
    check({tag, ".rdy"},       32'(rdy),       32'(m_rdy));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_fe));
    check({tag, ".overrun"},   32'(overrun),   32'(m_ov));
    check({tag, ".busy"},      32'(busy),      32'(1'b0));
    check({tag, ".state"},     32'(state),     32'(2'b00));
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_clear();
    m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic clr_same);
    if (stop_bit) begin
      m_ov   = (m_rdy && !clr_same) ? 1'b1 : (clr_same ? 1'b0 : m_ov);
      m_data = b;
      m_rdy  = 1'b1;
      m_fe   = 1'b0;
    end else begin
      if (clr_same) model_clear();
      m_fe = 1'b1;
    end
  endtask

  // One oversample tick: strobe high for one clock, low for the next
  task automatic do_tick(input logic rx_v, input logic clr_v);
    @(negedge clock);
    rx = rx_v; rxclk_en = 1'b1; rdy_clr = clr_v;
    @(negedge clock);
    rxclk_en = 1'b0; rdy_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0);
  endtask

  task automatic pulse_clr();
    @(negedge clock); rdy_clr = 1'b1;
    @(negedge clock); rdy_clr = 1'b0;
    model_clear();
  endtask

  // 160 ticks per frame; stop_at < 160 truncates the frame after that many ticks
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int clr_tick, input int stop_at);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int t = 0; t < 160; t++) begin
      if (t == stop_at) break;
      do_tick(bits[t / 16], 1'(t == clr_tick));
      if (t == 152) rdy_pre = rdy;
      if (t == 153) rdy_post = rdy;
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    resetn = 1'b0; rx = 1'b1; rxclk_en = 1'b0; rdy_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_idle("reset");
    resetn = 1'b1;
    idle(4);

    // Good frame 0xA5; rdy rises exactly at mid-stop
    send_frame(8'hA5, 1'b1, -1, 160);
    check("t1.rdy_before_mid_stop", 32'(rdy_pre), 32'(1'b0));
    check("t1.rdy_at_mid_stop", 32'(rdy_post), 32'(1'b1));
    model_frame(8'hA5, 1'b1, 1'b0);
    idle(12);
    check_idle("t1");

    // Short glitch: enters START then rejected
    for (int t = 0; t < 4; t++) do_tick(1'b0, 1'b0);
    check("t2.state_start", 32'(state), 32'(2'b01));
    check("t2.busy", 32'(busy), 32'(1'b1));
    idle(12);
    check_idle("t2");

    // Bad stop bit
    pulse_clr();
    send_frame(8'h3C, 1'b0, -1, 160);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle(12);
    check_idle("t3");
    pulse_clr();
    check_idle("t3.clr");

    // Back-to-back frames without acknowledge
    send_frame(8'h11, 1'b1, -1, 160);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, -1, 160);
    model_frame(8'h22, 1'b1, 1'b0);
    idle(12);
    check_idle("t4");
    pulse_clr();
    check_idle("t4.clr");

    // Acknowledge coinciding with stop completion
    send_frame(8'h55, 1'b1, -1, 160);
    model_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 153, 160);
    model_frame(8'h7E, 1'b1, 1'b1);
    idle(12);
    check_idle("t5");

    // Reset during data bit 4
    send_frame(8'h5A, 1'b1, -1, 85);
    check("t6.state_data", 32'(state), 32'(2'b10));
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_reset();
    check_idle("t6.reset");
    repeat (3) @(negedge clock);
    rx = 1'b1;
    resetn = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b1, -1, 160);
    model_frame(8'h81, 1'b1, 1'b0);
    idle(12);
    check_idle("t6.after");

    // Random frames, stop bits, gaps and acknowledges
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) pulse_clr();
      send_frame(rb, rs, -1, 160);
      model_frame(rb, rs, 1'b0);
      idle(int'($urandom_range(12, 20)));
      check_idle($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
